// File: rtl/mem_io_stage_pkg.sv
// Shared definitions for the memory stage: op encodings, FSM states, SP reset value.
package mem_io_stage_pkg;

  typedef enum logic [3:0] {
    MEM_NOP   = 4'd0,
    MEM_LOAD  = 4'd1,
    MEM_STORE = 4'd2,
    MEM_PUSH  = 4'd3,
    MEM_POP   = 4'd4,
    MEM_CALL  = 4'd5,
    MEM_RET   = 4'd6,
    MEM_IN    = 4'd7,
    MEM_OUT   = 4'd8
  } mem_op_e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_SECOND = 1'b1
  } mem_state_e;

  localparam logic [19:0] SP_RESET_DEF = 20'hFFFFE;

  function automatic logic is_two_cycle(input logic [3:0] op);
    return (op == MEM_CALL) || (op == MEM_RET);
  endfunction

endpackage

// File: rtl/mem_io_stage_sp.sv
// Stack pointer register; exposes SP and SP+1 so pops can address the top of stack directly.
module sp_unit #(
  parameter int              ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [ADDR_W-1:0] o_sp,
  output logic [ADDR_W-1:0] o_sp_p1,
  output logic [ADDR_W-1:0] o_sp_next
);

  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] w_sp_m1;

  // Modulo-2^ADDR_W arithmetic: wraps naturally at 0 and all-ones.
  assign o_sp_p1 = r_sp + 1'b1;
  assign w_sp_m1 = r_sp - 1'b1;
  assign o_sp    = r_sp;

  always_comb begin
    o_sp_next = r_sp;
    if (i_inc)      o_sp_next = o_sp_p1;
    else if (i_dec) o_sp_next = w_sp_m1;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_sp <= SP_RESET;
    else        r_sp <= o_sp_next;
  end

endmodule

// File: rtl/mem_io_stage.sv
// MEM stage: data-memory/stack access, I/O port control, CALL/RET two-cycle sequencing, MEM/WB latch.
module mem_io_stage
  import mem_io_stage_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [3:0]        ex_op,
  input  logic [15:0]       ex_result,
  input  logic [15:0]       ex_sdata,
  input  logic [31:0]       ex_pc,
  input  logic [2:0]        ex_rdst,
  input  logic              ex_wb_en,
  input  logic              flush,
  output logic              stall_o,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic              IOE,
  output logic              IOR,
  output logic              IOW,
  output logic [15:0]       io_result,
  input  logic [15:0]       io_in,
  output logic              wb_valid,
  output logic              wb_en,
  output logic [15:0]       wb_data,
  output logic [2:0]        wb_rdst,
  output logic [31:0]       wb_pc,
  output logic              wb_pc_load
);

  mem_state_e        r_state;
  logic [15:0]       r_pc_lo;
  logic              r_wb_valid;
  logic              r_wb_en;
  logic [15:0]       r_wb_data;
  logic [2:0]        r_wb_rdst;
  logic [31:0]       r_wb_pc;
  logic              r_wb_pc_load;

  logic              w_second;
  logic              w_live;
  logic              w_two;
  logic              w_sp_inc;
  logic              w_sp_dec;
  logic              w_wb_vld;
  logic [15:0]       w_wb_data;
  logic [ADDR_W-1:0] w_sp;
  logic [ADDR_W-1:0] w_sp_p1;
  logic [ADDR_W-1:0] w_sp_next;

  assign w_second = (r_state == S_SECOND);
  // Reset gates liveness so an abandoned CALL second half never strobes memory.
  assign w_live   = reset & (w_second | (ex_valid & ~flush));
  assign w_two    = is_two_cycle(ex_op);
  assign stall_o  = w_live & ~w_second & w_two;

  assign w_sp_inc = w_live & ((ex_op == MEM_POP)  | (ex_op == MEM_RET));
  assign w_sp_dec = w_live & ((ex_op == MEM_PUSH) | (ex_op == MEM_CALL));

  sp_unit #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_sp_inc),
    .i_dec     (w_sp_dec),
    .o_sp      (w_sp),
    .o_sp_p1   (w_sp_p1),
    .o_sp_next (w_sp_next)
  );

  always_comb begin
    mem_addr  = ADDR_W'(ex_result);
    mem_wdata = ex_sdata;
    mem_we    = 1'b0;
    IOE       = 1'b0;
    IOR       = 1'b0;
    IOW       = 1'b0;
    case (ex_op)
      MEM_LOAD:  mem_addr = ADDR_W'(ex_result);
      MEM_STORE: begin
        mem_addr = ADDR_W'(ex_result);
        mem_we   = w_live;
      end
      MEM_PUSH: begin
        mem_addr = w_sp;
        mem_we   = w_live;
      end
      MEM_POP:   mem_addr = w_sp_p1;
      MEM_CALL: begin
        mem_addr  = w_sp;
        mem_wdata = w_second ? ex_pc[15:0] : ex_pc[31:16];
        mem_we    = w_live;
      end
      MEM_RET:   mem_addr = w_sp_p1;
      MEM_IN: begin
        IOE = w_live;
        IOR = w_live;
      end
      MEM_OUT: begin
        IOE = w_live;
        IOW = w_live;
      end
      default: ;
    endcase
  end

  assign io_result = ex_result;

  // The stalled first half of CALL/RET produces no writeback; only its exit does.
  assign w_wb_vld = w_second | (w_live & ~w_two);

  always_comb begin
    w_wb_data = ex_result;
    case (ex_op)
      MEM_LOAD, MEM_POP: w_wb_data = mem_rdata;
      MEM_IN:            w_wb_data = io_in;
      default:           w_wb_data = ex_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_RUN;
      r_pc_lo      <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_en      <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rdst    <= '0;
      r_wb_pc      <= '0;
      r_wb_pc_load <= 1'b0;
    end else begin
      case (r_state)
        S_RUN:    if (stall_o) r_state <= S_SECOND;
        S_SECOND: r_state <= S_RUN;
        default:  r_state <= S_RUN;
      endcase
      if (stall_o && (ex_op == MEM_RET)) r_pc_lo <= mem_rdata;
      r_wb_valid   <= w_wb_vld;
      r_wb_en      <= ex_wb_en & w_wb_vld;
      r_wb_pc_load <= w_second & (ex_op == MEM_RET);
      if (w_second && (ex_op == MEM_RET)) r_wb_pc <= {mem_rdata, r_pc_lo};
      if (w_wb_vld) begin
        r_wb_data <= w_wb_data;
        r_wb_rdst <= ex_rdst;
      end
    end
  end

  assign wb_valid   = r_wb_valid;
  assign wb_en      = r_wb_en;
  assign wb_data    = r_wb_data;
  assign wb_rdst    = r_wb_rdst;
  assign wb_pc      = r_wb_pc;
  assign wb_pc_load = r_wb_pc_load;

endmodule

// File: tb/tb_mem_io_stage.sv
// Randomized bench for mem_io_stage with a behavioural stack/memory model and directed literal checks.
module tb_mem_io_stage;
  import mem_io_stage_pkg::*;

  localparam int AW = 20;
  localparam logic [AW-1:0] SPR = 20'hFFFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ex_valid, ex_wb_en, flush;
  logic [3:0]    ex_op;
  logic [15:0]   ex_result, ex_sdata, io_in;
  logic [31:0]   ex_pc;
  logic [2:0]    ex_rdst;
  logic          stall_o, mem_we, IOE, IOR, IOW;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata, io_result, wb_data;
  logic          wb_valid, wb_en, wb_pc_load;
  logic [2:0]    wb_rdst;
  logic [31:0]   wb_pc;

  mem_io_stage #(.ADDR_W(AW), .SP_RESET(SPR)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_result(ex_result), .ex_sdata(ex_sdata), .ex_pc(ex_pc),
    .ex_rdst(ex_rdst), .ex_wb_en(ex_wb_en), .flush(flush),
    .stall_o(stall_o), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .IOE(IOE), .IOR(IOR),
    .IOW(IOW), .io_result(io_result), .io_in(io_in),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_data(wb_data),
    .wb_rdst(wb_rdst), .wb_pc(wb_pc), .wb_pc_load(wb_pc_load)
  );

  // Memory seen by the DUT.
  logic [15:0] dmem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;
  assign mem_rdata = dmem[mem_addr];

  // Reference model state.
  logic [15:0]   ref_mem [logic [AW-1:0]];
  logic [AW-1:0] m_sp;
  logic          m_pend;
  logic [15:0]   m_pclo, m_wbd;
  logic [2:0]    m_wbr;
  logic [31:0]   m_wbpc;
  logic          m_wbv, m_wben, m_pcl;

  int n_chk = 0, n_fail = 0, stall_cnt = 0, pcl_cnt = 0;
  logic [AW-1:0] s_addr;
  logic          s_we, s_ioe, s_ior, s_iow;
  logic [15:0]   s_io;

  function automatic logic [15:0] rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    logic second, live, two, stall, we, memop, wbv, pcl;
    logic [AW-1:0] addr;
    logic [15:0] wd, r_at;
    second = m_pend;
    live   = reset && (second || (ex_valid && !flush));
    two    = (ex_op == MEM_CALL) || (ex_op == MEM_RET);
    stall  = live && !second && two;
    we     = live && (ex_op == MEM_STORE || ex_op == MEM_PUSH || ex_op == MEM_CALL);
    memop  = 1'b1;
    case (ex_op)
      MEM_LOAD, MEM_STORE: addr = AW'(ex_result);
      MEM_PUSH, MEM_CALL:  addr = m_sp;
      MEM_POP, MEM_RET:    addr = m_sp + 1'b1;
      default: begin addr = '0; memop = 1'b0; end
    endcase
    if (ex_op == MEM_CALL) wd = second ? ex_pc[15:0] : ex_pc[31:16];
    else                   wd = ex_sdata;
    #2;
    s_addr = mem_addr; s_we = mem_we; s_ioe = IOE; s_ior = IOR; s_iow = IOW; s_io = io_result;
    chk("stall_o", stall_o, stall);
    chk("mem_we", mem_we, we);
    chk("IOE", IOE, live && (ex_op == MEM_IN || ex_op == MEM_OUT));
    chk("IOR", IOR, live && ex_op == MEM_IN);
    chk("IOW", IOW, live && ex_op == MEM_OUT);
    chk("io_result", io_result, ex_result);
    if (live && memop) chk("mem_addr", mem_addr, addr);
    if (we) chk("mem_wdata", mem_wdata, wd);
    if (stall_o) stall_cnt++;
    @(posedge clk);
    if (!reset) begin
      m_sp = SPR; m_pend = 0; m_pclo = 0;
      m_wbv = 0; m_wben = 0; m_wbd = 0; m_wbr = 0; m_wbpc = 0; m_pcl = 0;
    end else begin
      r_at = rd(addr);
      wbv  = second || (live && !two);
      pcl  = 1'b0;
      if (live) begin
        case (ex_op)
          MEM_STORE: ref_mem[addr] = ex_sdata;
          MEM_PUSH:  begin ref_mem[m_sp] = ex_sdata; m_sp = m_sp - 1'b1; end
          MEM_CALL:  begin ref_mem[m_sp] = wd; m_sp = m_sp - 1'b1; end
          MEM_POP:   m_sp = m_sp + 1'b1;
          MEM_RET: begin
            if (!second) m_pclo = r_at;
            else begin m_wbpc = {r_at, m_pclo}; pcl = 1'b1; end
            m_sp = m_sp + 1'b1;
          end
          default: ;
        endcase
      end
      if (wbv) begin
        if (ex_op == MEM_LOAD || ex_op == MEM_POP) m_wbd = r_at;
        else if (ex_op == MEM_IN)                  m_wbd = io_in;
        else                                       m_wbd = ex_result;
        m_wbr = ex_rdst;
      end
      m_wbv = wbv; m_wben = ex_wb_en && wbv; m_pcl = pcl;
      m_pend = stall;
    end
    #1;
    chk("wb_valid", wb_valid, m_wbv);
    chk("wb_en", wb_en, m_wben);
    chk("wb_pc_load", wb_pc_load, m_pcl);
    chk("wb_data", wb_data, m_wbd);
    chk("wb_rdst", wb_rdst, m_wbr);
    chk("wb_pc", wb_pc, m_wbpc);
    if (wb_pc_load) pcl_cnt++;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] res, input logic [15:0] sd,
                       input logic [31:0] pc, input logic [2:0] rdst, input logic wben);
    ex_valid = 1; flush = 0; ex_op = op; ex_result = res; ex_sdata = sd;
    ex_pc = pc; ex_rdst = rdst; ex_wb_en = wben;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) dmem[i] = 16'h0000;
    m_sp = SPR; m_pend = 0; m_pclo = 0;
    m_wbv = 0; m_wben = 0; m_wbd = 0; m_wbr = 0; m_wbpc = 0; m_pcl = 0;
    io_in = 16'h0;
    drive(MEM_NOP, 16'h1111, 16'h0, 32'h0, 3'd1, 1'b1);
    reset = 0;
    cyc(); cyc();
    chk("reset_wb_valid", wb_valid, 1'b0);
    chk("reset_wb_data", wb_data, 16'h0);
    reset = 1;

    // PUSH then POP
    drive(MEM_PUSH, 16'h0, 16'hABCD, 32'h0, 3'd0, 1'b0); cyc();
    chk("push_addr", s_addr, 20'hFFFFE);
    chk("push_mem", dmem[20'hFFFFE], 16'hABCD);
    drive(MEM_POP, 16'h0, 16'h0, 32'h0, 3'd2, 1'b1); cyc();
    chk("pop_addr", s_addr, 20'hFFFFE);
    chk("pop_data", wb_data, 16'hABCD);

    // CALL then RET
    stall_cnt = 0; pcl_cnt = 0;
    drive(MEM_CALL, 16'h0, 16'h0, 32'h0001_2345, 3'd0, 1'b0); cyc(); cyc();
    drive(MEM_NOP, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0); cyc();
    chk("call_hi", dmem[20'hFFFFE], 16'h0001);
    chk("call_lo", dmem[20'hFFFFD], 16'h2345);
    chk("call_stall_cnt", stall_cnt, 1);
    drive(MEM_RET, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0); cyc(); cyc();
    chk("ret_pc", wb_pc, 32'h0001_2345);
    drive(MEM_NOP, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0); cyc();
    chk("ret_pcl_cnt", pcl_cnt, 1);
    drive(MEM_PUSH, 16'h0, 16'h7777, 32'h0, 3'd0, 1'b0); cyc();
    chk("ret_sp", s_addr, 20'hFFFFE);
    drive(MEM_POP, 16'h0, 16'h0, 32'h0, 3'd4, 1'b0); cyc();

    // IN / OUT
    io_in = 16'h5A5A;
    drive(MEM_IN, 16'h0, 16'h0, 32'h0, 3'd3, 1'b1); cyc();
    chk("in_ioe_ior", {s_ioe, s_ior}, 2'b11);
    chk("in_data", wb_data, 16'h5A5A);
    chk("in_rdst", wb_rdst, 3'd3);
    chk("in_wben", wb_en, 1'b1);
    drive(MEM_OUT, 16'h00FF, 16'h0, 32'h0, 3'd0, 1'b0); cyc();
    chk("out_ioe_iow_we", {s_ioe, s_iow, s_we}, 3'b110);
    chk("out_io", s_io, 16'h00FF);
    flush = 1; cyc();
    chk("out_flush_ioe", s_ioe, 1'b0);
    chk("out_flush_wbv", wb_valid, 1'b0);

    // Reset mid-CALL
    drive(MEM_CALL, 16'h0, 16'h0, 32'hAAAA_5555, 3'd0, 1'b0); cyc();
    reset = 0; cyc();
    chk("rstcall_we", s_we, 1'b0);
    chk("rstcall_wbv", wb_valid, 1'b0);
    reset = 1;
    drive(MEM_NOP, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0); cyc();
    chk("rstcall_no_second", dmem[20'hFFFFD], 16'h2345);
    drive(MEM_PUSH, 16'h0, 16'h4242, 32'h0, 3'd0, 1'b0); cyc();
    chk("rstcall_sp", s_addr, 20'hFFFFE);
    drive(MEM_POP, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0); cyc();

    // SP wrap
    cyc(); cyc();
    drive(MEM_PUSH, 16'h0, 16'h1234, 32'h0, 3'd0, 1'b0); cyc();
    chk("wrap_push_addr", s_addr, 20'h00000);
    chk("wrap_push_mem", dmem[20'h00000], 16'h1234);
    drive(MEM_POP, 16'h0, 16'h0, 32'h0, 3'd5, 1'b1); cyc();
    chk("wrap_pop_addr", s_addr, 20'h00000);
    chk("wrap_pop_data", wb_data, 16'h1234);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 149) != 0);
      if (!m_pend) begin
        int k;
        k = $urandom_range(0, 10);
        ex_op     = (k == 9) ? 4'hF : (k == 10) ? 4'h9 : 4'(k);
        ex_valid  = ($urandom_range(0, 7) != 0);
        ex_result = $urandom_range(0, 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        ex_sdata  = 16'($urandom);
        ex_pc     = $urandom;
        ex_rdst   = 3'($urandom);
        ex_wb_en  = 1'($urandom);
        io_in     = 16'($urandom);
      end
      flush = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
